// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types and constants for ID-stage branch hazard control.
//             FSM state encoding, per-producer stall requirements and the
//             register-match helper used by the dependency detector.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   // Stall cycles a branch must wait for each producer kind
   localparam logic [1:0] STALL_LOAD_ID  = 2'd2;
   localparam logic [1:0] STALL_ALU_ID   = 2'd1;
   localparam logic [1:0] STALL_LOAD_MEM = 2'd1;
   localparam logic [4:0] REG_ZERO       = 5'd0;

   // A producer feeds a source only if it writes a real (non-r0) register
   function automatic logic reg_match(input logic       reg_write,
                                      input logic [4:0] dest,
                                      input logic [4:0] src);
      return reg_write && (dest != REG_ZERO) && (dest == src);
   endfunction

endpackage
`default_nettype wire

// File: rtl/br_dep_detect.sv
`default_nettype none
// ============================================================================
//  Module   : br_dep_detect
//  Purpose  : Combinational dependency check of a branch's rs/rt against the
//             ID/EX and EX/MEM producers. Encodes the stall cycles required
//             and which operands can be taken from the EX/MEM ALU result.
//  Ports    : i_rs/i_rt            branch sources
//             i_id2ex_* / i_ex2mem_* producer regWrite, memRead, destination
//             o_need               stall cycles required (0..2)
//             o_fw_rs / o_fw_rt    operand forwardable from EX/MEM ALU result
//  Revision : 1.0  initial release
// ============================================================================
module br_dep_detect
   import hazard_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rt,
   input  logic       i_id2ex_regWrite,
   input  logic       i_id2ex_memRead,
   input  logic [4:0] i_id2ex_writeRegister,
   input  logic       i_ex2mem_regWrite,
   input  logic       i_ex2mem_memRead,
   input  logic [4:0] i_ex2mem_writeRegister,
   output logic [1:0] o_need,
   output logic       o_fw_rs,
   output logic       o_fw_rt
);

   logic w_id_rs, w_id_rt, w_mem_rs, w_mem_rt, w_id_any, w_mem_any;

   assign w_id_rs   = reg_match(i_id2ex_regWrite,  i_id2ex_writeRegister,  i_rs);
   assign w_id_rt   = reg_match(i_id2ex_regWrite,  i_id2ex_writeRegister,  i_rt);
   assign w_mem_rs  = reg_match(i_ex2mem_regWrite, i_ex2mem_writeRegister, i_rs);
   assign w_mem_rt  = reg_match(i_ex2mem_regWrite, i_ex2mem_writeRegister, i_rt);
   // OR-ing the operands means rs==rt collapses into one requirement
   assign w_id_any  = w_id_rs  | w_id_rt;
   assign w_mem_any = w_mem_rs | w_mem_rt;

   // Priority order realises the max over both operands and both stages
   always_comb begin
      o_need = 2'd0;
      if (w_id_any && i_id2ex_memRead)
         o_need = STALL_LOAD_ID;
      else if (w_id_any)
         o_need = STALL_ALU_ID;
      else if (w_mem_any && i_ex2mem_memRead)
         o_need = STALL_LOAD_MEM;
   end

   assign o_fw_rs = w_mem_rs & ~i_ex2mem_memRead;
   assign o_fw_rt = w_mem_rt & ~i_ex2mem_memRead;

endmodule
`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_hazard_ctrl
//  Purpose  : Sequences ID-stage branch resolution: stalls PC and IF/ID and
//             bubbles ID/EX while a branch source is still being produced,
//             selects EX/MEM forwarding for the comparator and flushes IF/ID
//             on a taken branch. Keeps saturating stall/flush counters.
//  Ports    : clk, rst_n (synchronous, active low)
//             i_id_is_branch, i_if2id_rs/rt, i_branch_taken
//             i_id2ex_* / i_ex2mem_*  producer info
//             o_pc_write, o_if2id_write, o_id2ex_bubble, o_if2id_flush
//             o_fw_rs, o_fw_rt, o_busy, o_stall_cnt, o_flush_cnt
//  Revision : 1.0  initial release
// ============================================================================
module branch_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_id_is_branch,
   input  logic [4:0]       i_if2id_rs,
   input  logic [4:0]       i_if2id_rt,
   input  logic             i_branch_taken,
   input  logic             i_id2ex_regWrite,
   input  logic             i_id2ex_memRead,
   input  logic [4:0]       i_id2ex_writeRegister,
   input  logic             i_ex2mem_regWrite,
   input  logic             i_ex2mem_memRead,
   input  logic [4:0]       i_ex2mem_writeRegister,
   output logic             o_pc_write,
   output logic             o_if2id_write,
   output logic             o_id2ex_bubble,
   output logic             o_if2id_flush,
   output logic             o_fw_rs,
   output logic             o_fw_rt,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_remaining, w_remaining_nxt;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic [1:0]       w_need;
   logic             w_det_fw_rs, w_det_fw_rt;
   logic             w_hold, w_flush, w_fw_rs, w_fw_rt;

   br_dep_detect u_detect (
      .i_rs                   (i_if2id_rs),
      .i_rt                   (i_if2id_rt),
      .i_id2ex_regWrite       (i_id2ex_regWrite),
      .i_id2ex_memRead        (i_id2ex_memRead),
      .i_id2ex_writeRegister  (i_id2ex_writeRegister),
      .i_ex2mem_regWrite      (i_ex2mem_regWrite),
      .i_ex2mem_memRead       (i_ex2mem_memRead),
      .i_ex2mem_writeRegister (i_ex2mem_writeRegister),
      .o_need                 (w_need),
      .o_fw_rs                (w_det_fw_rs),
      .o_fw_rt                (w_det_fw_rt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_remaining <= 2'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         if (w_hold && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   // The detection cycle in IDLE is itself the first stall cycle, so STALL
   // only covers the cycles still owed after it (r_remaining). A single-cycle
   // requirement therefore never leaves IDLE; the branch is re-evaluated on
   // the following cycle once the producer has advanced.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_hold          = 1'b0;
      w_flush         = 1'b0;
      w_fw_rs         = 1'b0;
      w_fw_rt         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_id_is_branch) begin
               if (w_need != 2'd0) begin
                  w_hold          = 1'b1;
                  w_remaining_nxt = w_need - 2'd1;
                  if (w_need > 2'd1)
                     w_state_nxt = ST_STALL;
               end else begin
                  w_fw_rs = w_det_fw_rs;
                  w_fw_rt = w_det_fw_rt;
                  w_flush = i_branch_taken;
               end
            end
         end
         ST_STALL: begin
            w_hold = 1'b1;
            if (r_remaining > 2'd1) begin
               w_remaining_nxt = r_remaining - 2'd1;
            end else begin
               w_remaining_nxt = 2'd0;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = 2'd0;
         end
      endcase
   end

   assign o_pc_write     = ~w_hold;
   assign o_if2id_write  = ~w_hold;
   assign o_id2ex_bubble = w_hold;
   assign o_if2id_flush  = w_flush;
   assign o_fw_rs        = w_fw_rs;
   assign o_fw_rt        = w_fw_rt;
   // Busy spans every cycle the pipeline is held, including the detect cycle
   assign o_busy         = w_hold;
   assign o_stall_cnt    = r_stall_cnt;
   assign o_flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_hazard_ctrl
//  Purpose  : Self-checking bench for branch_hazard_ctrl. Each scenario task
//             queues expected control vectors as it drives stimulus and pops
//             them when the outputs are sampled on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_hazard_ctrl;

   localparam int CNT_W = 16;

   // control vector: {pc_write, if2id_write, bubble, flush, fw_rs, fw_rt, busy}
   localparam logic [6:0] V_IDLE = 7'b1100000;
   localparam logic [6:0] V_HOLD = 7'b0010001;

   typedef struct {
      logic       rst;
      logic       br;
      logic [4:0] rs, rt;
      logic       tk;
      logic       idrw, idmr;
      logic [4:0] idrd;
      logic       mrw, mmr;
      logic [4:0] mrd;
      logic [6:0] exp;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_is_branch = 1'b0, branch_taken = 1'b0;
   logic [4:0] rs = '0, rt = '0;
   logic id2ex_regWrite = 1'b0, id2ex_memRead = 1'b0;
   logic [4:0] id2ex_writeRegister = '0;
   logic ex2mem_regWrite = 1'b0, ex2mem_memRead = 1'b0;
   logic [4:0] ex2mem_writeRegister = '0;
   logic pc_write, if2id_write, id2ex_bubble, if2id_flush, fw_rs, fw_rt, busy;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0] w_obs;

   int total = 0;
   int bad   = 0;
   logic [CNT_W-1:0] exp_stall = '0, exp_flush = '0;
   logic [6:0] sb[$];

   always #5 clk = ~clk;

   branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .i_id_is_branch         (id_is_branch),
      .i_if2id_rs             (rs),
      .i_if2id_rt             (rt),
      .i_branch_taken         (branch_taken),
      .i_id2ex_regWrite       (id2ex_regWrite),
      .i_id2ex_memRead        (id2ex_memRead),
      .i_id2ex_writeRegister  (id2ex_writeRegister),
      .i_ex2mem_regWrite      (ex2mem_regWrite),
      .i_ex2mem_memRead       (ex2mem_memRead),
      .i_ex2mem_writeRegister (ex2mem_writeRegister),
      .o_pc_write             (pc_write),
      .o_if2id_write          (if2id_write),
      .o_id2ex_bubble         (id2ex_bubble),
      .o_if2id_flush          (if2id_flush),
      .o_fw_rs                (fw_rs),
      .o_fw_rt                (fw_rt),
      .o_busy                 (busy),
      .o_stall_cnt            (stall_cnt),
      .o_flush_cnt            (flush_cnt)
   );

   assign w_obs = {pc_write, if2id_write, id2ex_bubble, if2id_flush, fw_rs, fw_rt, busy};

   function automatic stim_t mk(input logic rst, br, input logic [4:0] s, t,
                                input logic tk, idrw, idmr, input logic [4:0] idrd,
                                input logic mrw, mmr, input logic [4:0] mrd,
                                input logic [6:0] exp);
      stim_t r;
      r.rst = rst; r.br = br; r.rs = s; r.rt = t; r.tk = tk;
      r.idrw = idrw; r.idmr = idmr; r.idrd = idrd;
      r.mrw = mrw; r.mmr = mmr; r.mrd = mrd; r.exp = exp;
      return r;
   endfunction

   // Drives one cycle of stimulus and queues what the outputs must be
   task automatic put(input stim_t s);
      rst_n = s.rst; id_is_branch = s.br; rs = s.rs; rt = s.rt; branch_taken = s.tk;
      id2ex_regWrite = s.idrw; id2ex_memRead = s.idmr; id2ex_writeRegister = s.idrd;
      ex2mem_regWrite = s.mrw; ex2mem_memRead = s.mmr; ex2mem_writeRegister = s.mrd;
      sb.push_back(s.exp);
   endtask

   // Reference counter update from the expected vector of the cycle just sampled
   task automatic model_counters(input logic rst, input logic [6:0] e);
      if (!rst) begin
         exp_stall = '0; exp_flush = '0;
      end else begin
         if (!e[6] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
         if (e[3] && exp_flush != '1)  exp_flush = exp_flush + 1'b1;
      end
   endtask

   task automatic test_reset();
      stim_t st[$];
      logic [6:0] e;
      put(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_IDLE));
      void'(sb.pop_front());
      repeat (2) @(posedge clk);
      #1;
      exp_stall = '0; exp_flush = '0;
      st.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, V_IDLE));
      st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_IDLE));
      foreach (st[i]) begin
         put(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (w_obs !== e) begin
            bad++; $display("FAIL reset[%0d] ctrl got=%b want=%b", i, w_obs, e);
         end
         total++;
         if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
            bad++; $display("FAIL reset_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
         end
         model_counters(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   // add r3 in ID/EX, beq r3,r4: one stall, then forward rs from EX/MEM and flush
   task automatic test_alu_id();
      stim_t st[$];
      logic [6:0] e;
      st.push_back(mk(1, 1, 3, 4, 1, 1, 0, 3, 0, 0, 0, V_HOLD));
      st.push_back(mk(1, 1, 3, 4, 1, 0, 0, 0, 1, 0, 3, 7'b1101100));
      st.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, V_IDLE));
      foreach (st[i]) begin
         put(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (w_obs !== e) begin
            bad++; $display("FAIL alu_id[%0d] ctrl got=%b want=%b", i, w_obs, e);
         end
         total++;
         if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
            bad++; $display("FAIL alu_id_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
         end
         model_counters(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   // lw r5 in ID/EX, bne r1,r5: two held cycles; taken during the hold is ignored
   task automatic test_load_id();
      stim_t st[$];
      logic [6:0] e;
      st.push_back(mk(1, 1, 1, 5, 0, 1, 1, 5, 0, 0, 0, V_HOLD));
      st.push_back(mk(1, 1, 1, 5, 1, 1, 1, 5, 0, 0, 0, V_HOLD));
      st.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, V_IDLE));
      st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_IDLE));
      foreach (st[i]) begin
         put(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (w_obs !== e) begin
            bad++; $display("FAIL load_id[%0d] ctrl got=%b want=%b", i, w_obs, e);
         end
         total++;
         if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
            bad++; $display("FAIL load_id_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
         end
         model_counters(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   // EX/MEM producers: load stalls once; ALU result forwards on rs or rt
   task automatic test_ex2mem();
      stim_t st[$];
      logic [6:0] e;
      st.push_back(mk(1, 1, 5, 5, 1, 0, 0, 0, 1, 1, 5, V_HOLD));
      st.push_back(mk(1, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, V_IDLE));
      st.push_back(mk(1, 1, 7, 2, 0, 0, 0, 0, 1, 0, 7, 7'b1100100));
      st.push_back(mk(1, 1, 2, 7, 1, 0, 0, 0, 1, 0, 7, 7'b1101010));
      st.push_back(mk(1, 1, 7, 7, 0, 0, 0, 0, 1, 0, 7, 7'b1100110));
      foreach (st[i]) begin
         put(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (w_obs !== e) begin
            bad++; $display("FAIL ex2mem[%0d] ctrl got=%b want=%b", i, w_obs, e);
         end
         total++;
         if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
            bad++; $display("FAIL ex2mem_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
         end
         model_counters(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   // r0 destination, regWrite=0 producer and non-branch never stall or forward
   task automatic test_no_hazard();
      stim_t st[$];
      logic [6:0] e;
      st.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, V_IDLE));
      st.push_back(mk(1, 1, 3, 3, 0, 0, 1, 3, 0, 0, 3, V_IDLE));
      st.push_back(mk(1, 0, 1, 1, 1, 1, 1, 1, 1, 0, 1, V_IDLE));
      foreach (st[i]) begin
         put(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (w_obs !== e) begin
            bad++; $display("FAIL no_hazard[%0d] ctrl got=%b want=%b", i, w_obs, e);
         end
         total++;
         if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
            bad++; $display("FAIL no_hazard_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
         end
         model_counters(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   // Reset asserted on the second cycle of a load stall abandons it
   task automatic test_reset_mid_stall();
      stim_t st[$];
      logic [6:0] e;
      st.push_back(mk(1, 1, 5, 1, 0, 1, 1, 5, 0, 0, 0, V_HOLD));
      st.push_back(mk(0, 1, 5, 1, 1, 1, 1, 5, 0, 0, 0, V_HOLD));
      st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_IDLE));
      st.push_back(mk(1, 1, 4, 6, 1, 0, 0, 0, 0, 0, 0, 7'b1101000));
      foreach (st[i]) begin
         put(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (w_obs !== e) begin
            bad++; $display("FAIL rst_mid[%0d] ctrl got=%b want=%b", i, w_obs, e);
         end
         total++;
         if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
            bad++; $display("FAIL rst_mid_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
         end
         model_counters(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   // A persistent load hazard holds the pipeline every cycle; counter must stop at all-ones
   task automatic test_saturation();
      logic [CNT_W-1:0] all_ones;
      all_ones = '1;
      rst_n = 1'b0; id_is_branch = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; id_is_branch = 1'b1; rs = 5'd9; rt = 5'd2;
      id2ex_regWrite = 1'b1; id2ex_memRead = 1'b1; id2ex_writeRegister = 5'd9;
      ex2mem_regWrite = 1'b0;
      repeat ((1 << CNT_W) - 2) @(posedge clk);
      #1;
      total++;
      if (stall_cnt !== all_ones - 1'b1) begin
         bad++; $display("FAIL sat_pre got=%0d want=%0d", stall_cnt, all_ones - 1'b1);
      end
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (stall_cnt !== all_ones || pc_write !== 1'b0) begin
         bad++; $display("FAIL sat_hold got=%0d pc_write=%b want=%0d pc_write=0", stall_cnt, pc_write, all_ones);
      end
      id_is_branch = 1'b0; id2ex_regWrite = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (stall_cnt !== all_ones || flush_cnt !== '0 || pc_write !== 1'b1) begin
         bad++; $display("FAIL sat_after got=%0d/%0d pc_write=%b want=%0d/0 pc_write=1", stall_cnt, flush_cnt, pc_write, all_ones);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu_id();
      test_load_id();
      test_ex2mem();
      test_no_hazard();
      test_reset_mid_stall();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
